// File: rtl/vec_store_seq.sv
// vec_store_seq: writes the lanes of a captured vector result to memory one
// lane per accepted beat, skipping masked-off lanes, then pulses done.
module vec_store_seq #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned LANE_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LANES*LANE_W-1:0]  ResultV,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [LANES-1:0]         lane_mask,
    input  logic                     mem_ready,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LANE_W-1:0]        mem_wdata,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned VEC_W = LANES * LANE_W;
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    lane;
    logic [VEC_W-1:0]    cap_vec;
    logic [ADDR_W-1:0]   cap_base;
    logic [LANES-1:0]    cap_mask;

    logic [LANE_W-1:0]   cap_lanes [LANES];
    logic [IDX_W-1:0]    nxt_lane;
    logic                nxt_en;
    logic [ADDR_W-1:0]   nxt_addr;
    logic [LANE_W-1:0]   nxt_data;
    logic                advance;

    // Beat that will be presented after the current lane retires.
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            cap_lanes[i] = cap_vec[i*LANE_W +: LANE_W];
        end
        nxt_lane = (lane == LAST_LANE) ? '0 : lane + IDX_W'(1);
        nxt_en   = cap_mask[nxt_lane];
        nxt_addr = cap_base + (ADDR_W'(nxt_lane) << 2);
        nxt_data = cap_lanes[nxt_lane];
        advance  = !cap_mask[lane] || mem_ready;
    end

    // Sequencer with registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lane      <= '0;
            cap_vec   <= '0;
            cap_base  <= '0;
            cap_mask  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= WRITE;
                        lane      <= '0;
                        cap_vec   <= ResultV;
                        cap_base  <= base_addr;
                        cap_mask  <= lane_mask;
                        busy      <= 1'b1;
                        mem_we    <= lane_mask[0];
                        mem_addr  <= lane_mask[0] ? base_addr : '0;
                        mem_wdata <= lane_mask[0] ? ResultV[LANE_W-1:0] : '0;
                    end
                end
                WRITE: begin
                    if (advance) begin
                        if (lane == LAST_LANE) begin
                            state     <= DONE;
                            lane      <= '0;
                            mem_we    <= 1'b0;
                            mem_addr  <= '0;
                            mem_wdata <= '0;
                            done      <= 1'b1;
                        end else begin
                            lane      <= nxt_lane;
                            mem_we    <= nxt_en;
                            mem_addr  <= nxt_en ? nxt_addr : '0;
                            mem_wdata <= nxt_en ? nxt_data : '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_store_seq.sv
// Scoreboard bench for vec_store_seq: a lane-level model precomputes every
// expected write and done pulse; a negedge monitor pops and compares.
module tb_vec_store_seq;

    localparam int unsigned LANES  = 16;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned VEC_W  = LANES * LANE_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [VEC_W-1:0]    result_v;
    logic [ADDR_W-1:0]   base_addr;
    logic [LANES-1:0]    lane_mask;
    logic                mem_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [LANE_W-1:0]   mem_wdata;
    logic                busy;
    logic                done;

    vec_store_seq #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ResultV   (result_v),
        .base_addr (base_addr),
        .lane_mask (lane_mask),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LANE_W-1:0] data;
        int unsigned       cyc;
    } wr_t;

    wr_t         wq[$];
    int unsigned dq[$];
    bit          rdy[256];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    bit          mon_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Monitor: compares accepted writes, idle bus values, holds and done pulses.
    wr_t               exp_wr;
    logic              prev_stall = 1'b0;
    logic              prev_rst   = 1'b0;
    logic [ADDR_W-1:0] prev_addr  = '0;
    logic [LANE_W-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall && !prev_rst) begin
                check("hold_we", mem_we, 1);
                check("hold_addr", mem_addr, prev_addr);
                check("hold_data", mem_wdata, prev_data);
            end
            if (mem_we && mem_ready) begin
                if (wq.size() == 0) begin
                    flag_fail("extra_write");
                end else begin
                    exp_wr = wq.pop_front();
                    check("wr_addr", mem_addr, exp_wr.addr);
                    check("wr_data", mem_wdata, exp_wr.data);
                    check("wr_cycle", cyc, exp_wr.cyc);
                end
            end
            if (!mem_we) begin
                check("idle_addr", mem_addr, 0);
                check("idle_data", mem_wdata, 0);
            end
            if (done) begin
                check("done_busy", busy, 1);
                if (dq.size() == 0) flag_fail("extra_done");
                else check("done_cycle", cyc, dq.pop_front());
            end
            prev_stall = mem_we && !mem_ready;
            prev_rst   = rst;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
        end
    end

    // Lane-by-lane model: each enabled lane waits for a ready cycle, a disabled
    // lane costs one cycle; writes after a reset cycle are dropped with done.
    task automatic model(input int unsigned t0, input logic [ADDR_W-1:0] base,
                         input logic [LANES-1:0] mask, input logic [VEC_W-1:0] vec,
                         input int unsigned rst_k, output int unsigned dk);
        int unsigned k;
        wr_t w;
        k = 1;
        for (int ln = 0; ln < int'(LANES); ln++) begin
            if (mask[ln]) begin
                while (!rdy[k] && k < 255) k++;
            end
            if (rst_k != 0 && k > rst_k) break;
            if (mask[ln]) begin
                w.addr = ADDR_W'(base + ADDR_W'(4 * ln));
                w.data = vec[ln*LANE_W +: LANE_W];
                w.cyc  = t0 + k;
                wq.push_back(w);
            end
            k++;
        end
        dk = k;
        if (rst_k == 0 || k <= rst_k) dq.push_back(t0 + k);
    endtask

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int i = 0; i < int'(LANES); i++) v[i*LANE_W +: LANE_W] = $urandom;
        return v;
    endfunction

    // Issue one store; mode 0 all ready, 1 random ready, 2 stall offsets 3..5.
    task automatic run_txn(input logic [ADDR_W-1:0] base, input logic [LANES-1:0] mask,
                           input logic [VEC_W-1:0] vec, input int unsigned rst_k,
                           input int unsigned mode);
        int unsigned t0;
        int unsigned dk;
        int unsigned end_k;
        for (int k = 0; k < 256; k++) begin
            rdy[k] = (mode == 1) ? ($urandom_range(0, 9) < 7) : 1'b1;
            if (mode == 2 && k >= 3 && k <= 5) rdy[k] = 1'b0;
            if (k >= 200) rdy[k] = 1'b1;
        end
        t0 = cyc;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_we", mem_we, 0);
        start     = 1'b1;
        result_v  = vec;
        base_addr = base;
        lane_mask = mask;
        mem_ready = 1'b1;
        model(t0, base, mask, vec, rst_k, dk);
        end_k = (rst_k != 0) ? rst_k : dk;
        for (int unsigned k = 1; k <= end_k; k++) begin
            @(posedge clk); #1;
            mem_ready = rdy[k];
            start     = (k == dk) ? 1'b1 : 1'($urandom_range(0, 1));
            result_v  = rand_vec();
            base_addr = $urandom;
            lane_mask = LANES'($urandom);
            rst       = (k == rst_k);
        end
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        if (rst_k != 0) begin
            check("abort_we", mem_we, 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            @(posedge clk); #1;
        end
    endtask

    logic [VEC_W-1:0] seq_vec;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        result_v  = '1;
        base_addr = '1;
        lane_mask = '1;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst    = 1'b0;
        start  = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < int'(LANES); i++) seq_vec[i*LANE_W +: LANE_W] = 32'hA000_0000 + i;
        run_txn(32'h0000_1000, 16'hFFFF, seq_vec, 0, 0);
        run_txn(32'h0000_1000, 16'hFFFF, seq_vec, 0, 2);
        run_txn(32'h0000_1000, 16'h8001, seq_vec, 0, 0);
        run_txn(32'hFFFF_FFF8, 16'hFFFF, rand_vec(), 0, 0);
        run_txn(32'h0000_1000, 16'hFFFF, seq_vec, 8, 0);
        run_txn(32'h0000_1000, 16'hFFFF, seq_vec, 0, 0);
        run_txn(32'h0000_2000, 16'h0000, rand_vec(), 0, 1);
        for (int t = 0; t < 20; t++) begin
            run_txn($urandom, LANES'($urandom), rand_vec(), (t % 7 == 3) ? 6 + (t % 5) : 0, 1);
        end

        repeat (4) @(posedge clk);
        #1;
        check("wq_empty", wq.size(), 0);
        check("dq_empty", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vec_store_seq.md
VEC_STORE_SEQ -- requirements
Module: vec_store_seq

Interface
REQ-001 SHALL have parameter LANES, default 16: number of vector lanes.
REQ-002 SHALL have parameter LANE_W, default 32: lane width in bits; ResultV width = LANES*LANE_W.
REQ-003 SHALL have parameter ADDR_W, default 32: memory address width.
REQ-004 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  request to store one vector; sampled only in IDLE.
REQ-008 ResultV  input  LANES*LANE_W  vector result; lane i = bits [i*LANE_W +: LANE_W].
REQ-009 base_addr  input  ADDR_W  byte address of lane 0.
REQ-010 lane_mask  input  LANES  bit i = 1 means write lane i.
REQ-011 mem_ready  input  1  memory accepts the write presented this cycle.
REQ-012 mem_we  output  1  write strobe.
REQ-013 mem_addr  output  ADDR_W  write byte address.
REQ-014 mem_wdata  output  LANE_W  write data.
REQ-015 busy  output  1  high while not in IDLE.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, WRITE, DONE.
REQ-018 IDLE with start=1: capture ResultV, base_addr and lane_mask into internal registers, set lane index to 0, go to WRITE next cycle.
REQ-019 In WRITE, the current lane SHALL be taken from the captured vector, not the live ResultV input; input changes after capture have no effect.
REQ-020 In WRITE with mask bit of current lane = 1: mem_we=1, mem_addr = captured base + 4*lane (modulo 2^ADDR_W), mem_wdata = captured lane data.
REQ-021 An enabled lane SHALL advance only in a cycle where mem_ready=1; with mem_ready=0, mem_we, mem_addr and mem_wdata SHALL hold stable.
REQ-022 A disabled lane (mask bit 0) SHALL keep mem_we=0 and advance in one cycle regardless of mem_ready.
REQ-023 Lanes SHALL be visited strictly in ascending order 0..LANES-1.
REQ-024 Advancing from lane LANES-1 SHALL go to DONE; DONE lasts exactly one cycle with done=1, then IDLE.
REQ-025 Outside WRITE with an enabled lane, mem_we SHALL be 0 and mem_addr and mem_wdata SHALL be 0.
REQ-026 busy SHALL be 1 in WRITE and DONE and 0 in IDLE.
REQ-027 start while busy SHALL be ignored: no queueing and no recapture.
REQ-028 start in the DONE cycle SHALL be ignored; a new start is accepted in the following IDLE cycle.
REQ-029 lane_mask=0 SHALL still traverse all LANES lanes, taking LANES cycles with no writes, then DONE.
REQ-030 Latency with mem_ready held 1: start accepted at cycle 0, lane i written in cycle i+1, done in cycle LANES+1.

Reset
REQ-031 When rst=1, the block SHALL enter IDLE; mem_we, mem_addr, mem_wdata, busy and done SHALL all be 0 in the next cycle; lane index and captured registers SHALL be 0.
REQ-032 rst SHALL take priority over start and mem_ready.
REQ-033 rst mid-WRITE SHALL abort the sequence: no further writes and no done pulse.

Verification
REQ-034 Full store: base_addr=0x1000, lane_mask=0xFFFF, ResultV lane i = 0xA0000000+i, mem_ready=1 -> 16 writes at 0x1000..0x103C with data 0xA0000000..0xA000000F in cycles 1..16; done=1 in cycle 17 only.
REQ-035 Backpressure: as REQ-034, with mem_ready=0 in cycles 3-5 -> lane 2 held at addr 0x1008 for 4 cycles; done in cycle 20.
REQ-036 Mask: lane_mask=0x8001 -> exactly 2 writes, at 0x1000 (cycle 1) and 0x103C (cycle 16); done in cycle 17; data matches lanes 0 and 15.
REQ-037 Wrap and capture: base_addr=0xFFFFFFF8, ResultV changed the cycle after start -> lane 2 written at 0x00000000 using originally captured data.
REQ-038 Reset/start abuse: start pulsed in cycle 5 is ignored; rst in cycle 8 -> mem_we=0 and busy=0 from cycle 9, no done; new start in cycle 10 restarts at lane 0.
